// File: rtl/ppu_bg_scroll.sv
// Purpose : PPU background fetch pipeline with loopy-style scroll register v.
// Latency : pixel is combinational from the shift registers (zero added latency); VRAM_addr is registered.
// Backpressure: none; advances every clk while rendering_en=1 and freezes completely while it is 0.
//
// Ports
//   clk, reset (async, active-low)        clock and reset
//   rendering_en                          background rendering enable
//   VRAM_data_in / VRAM_addr              VRAM read data / registered read address
//   x_idx, scanline                       current dot (0..340) and scanline (0..PRERENDER_LINE)
//   bg_pt_addr                            background pattern table select
//   scroll_t                              temporary address t {fineY, NT[1:0], coarseY, coarseX}
//   fine_x                                fine X scroll (selects the shift register tap)
//   show_left                             background enable for columns 0..7
//   pixel                                 palette index {AT_hi, AT_lo, PT_hi, PT_lo}
//
// Build option: define PPU_BG_CLIP_EN to blank columns 0..7 when show_left=0.
// Without it show_left is ignored.

module ppu_bg_scroll #(
    parameter logic [15:0] NT_BASE        = 16'h2000,
    parameter logic [15:0] AT_OFFSET      = 16'h03C0,
    parameter int          VISIBLE_LINES  = 240,
    parameter int          PRERENDER_LINE = 261
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rendering_en,
    input  logic [7:0]  VRAM_data_in,
    output logic [15:0] VRAM_addr,
    input  logic [9:0]  x_idx,
    input  logic [9:0]  scanline,
    input  logic        bg_pt_addr,
    input  logic [14:0] scroll_t,
    input  logic [2:0]  fine_x,
    input  logic        show_left,
    output logic [3:0]  pixel
);

    localparam logic [9:0] VIS_L = 10'(VISIBLE_LINES);
    localparam logic [9:0] PRE_L = 10'(PRERENDER_LINE);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [14:0] v;
    logic [7:0]  nt_idx;
    logic [1:0]  at_bits;
    logic [7:0]  pt_lo_lat;
    logic [7:0]  pt_hi_lat;
    logic [15:0] sr_pt_lo;
    logic [15:0] sr_pt_hi;
    logic [15:0] sr_at_lo;
    logic [15:0] sr_at_hi;

    logic [14:0] v_nx;
    logic [7:0]  nt_idx_nx;
    logic [1:0]  at_bits_nx;
    logic [7:0]  pt_lo_lat_nx;
    logic [7:0]  pt_hi_lat_nx;
    logic [15:0] sr_pt_lo_nx;
    logic [15:0] sr_pt_hi_nx;
    logic [15:0] sr_at_lo_nx;
    logic [15:0] sr_at_hi_nx;
    logic [15:0] addr_nx;

    // ------------------------------------------------------------------
    // Timing windows
    // ------------------------------------------------------------------
    logic       active_line;
    logic       fetch_win;
    logic       pre_vcopy;
    logic [2:0] phase;

    assign active_line = (scanline < VIS_L) || (scanline == PRE_L);
    assign fetch_win   = active_line &&
                         ((x_idx < 10'd256) || ((x_idx >= 10'd320) && (x_idx < 10'd336)));
    assign pre_vcopy   = (scanline == PRE_L) && (x_idx >= 10'd280) && (x_idx <= 10'd304);
    assign phase       = x_idx[2:0];

    // ------------------------------------------------------------------
    // Scroll helpers
    // ------------------------------------------------------------------
    // Coarse X wraps into the horizontally adjacent nametable.
    function automatic logic [14:0] coarse_x_inc(input logic [14:0] vi);
        logic [14:0] vo;
        vo = vi;
        if (vi[4:0] == 5'd31) begin
            vo[4:0] = 5'd0;
            vo[10]  = ~vi[10];
        end else begin
            vo[4:0] = vi[4:0] + 5'd1;
        end
        return vo;
    endfunction

    // Row 29 is the last tile row of a nametable, so it wraps into the
    // vertically adjacent one. Rows 30/31 sit in attribute space; scrolling
    // from there wraps to row 0 of the same nametable.
    function automatic logic [14:0] y_inc(input logic [14:0] vi);
        logic [14:0] vo;
        vo = vi;
        if (vi[14:12] != 3'd7) begin
            vo[14:12] = vi[14:12] + 3'd1;
        end else begin
            vo[14:12] = 3'd0;
            if (vi[9:5] == 5'd29) begin
                vo[9:5] = 5'd0;
                vo[11]  = ~vi[11];
            end else if (vi[9:5] == 5'd31) begin
                vo[9:5] = 5'd0;
            end else begin
                vo[9:5] = vi[9:5] + 5'd1;
            end
        end
        return vo;
    endfunction

    // Pixels are shifted out LSB-first, so the leftmost pattern bit (bit 7)
    // must land at the lowest position of the reloaded byte.
    function automatic logic [7:0] rev8(input logic [7:0] b);
        return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        v_nx         = v;
        nt_idx_nx    = nt_idx;
        at_bits_nx   = at_bits;
        pt_lo_lat_nx = pt_lo_lat;
        pt_hi_lat_nx = pt_hi_lat;
        sr_pt_lo_nx  = sr_pt_lo;
        sr_pt_hi_nx  = sr_pt_hi;
        sr_at_lo_nx  = sr_at_lo;
        sr_at_hi_nx  = sr_at_hi;
        addr_nx      = VRAM_addr;

        if (rendering_en) begin
            if (fetch_win) begin
                sr_pt_lo_nx = {1'b0, sr_pt_lo[15:1]};
                sr_pt_hi_nx = {1'b0, sr_pt_hi[15:1]};
                sr_at_lo_nx = {1'b0, sr_at_lo[15:1]};
                sr_at_hi_nx = {1'b0, sr_at_hi[15:1]};

                case (phase)
                    3'd0: addr_nx = NT_BASE | {4'b0000, v[11:0]};
                    3'd1: nt_idx_nx = VRAM_data_in;
                    3'd2: addr_nx = NT_BASE | AT_OFFSET |
                                    {4'b0000, v[11:10], 4'b0000, v[9:7], v[4:2]};
                    3'd3: begin
                        // Quadrant within the 32x32-pixel attribute cell.
                        case ({v[6], v[1]})
                            2'b00:   at_bits_nx = VRAM_data_in[1:0];
                            2'b01:   at_bits_nx = VRAM_data_in[3:2];
                            2'b10:   at_bits_nx = VRAM_data_in[5:4];
                            default: at_bits_nx = VRAM_data_in[7:6];
                        endcase
                    end
                    3'd4: addr_nx = {3'b000, bg_pt_addr, nt_idx, 1'b0, v[14:12]};
                    3'd5: begin
                        pt_lo_lat_nx = VRAM_data_in;
                        addr_nx      = {3'b000, bg_pt_addr, nt_idx, 1'b1, v[14:12]};
                    end
                    3'd6: pt_hi_lat_nx = VRAM_data_in;
                    default: begin
                        // Reload the upper byte in the same cycle as this dot's shift.
                        sr_pt_lo_nx = {rev8(pt_lo_lat), sr_pt_lo[8:1]};
                        sr_pt_hi_nx = {rev8(pt_hi_lat), sr_pt_hi[8:1]};
                        sr_at_lo_nx = {{8{at_bits[0]}}, sr_at_lo[8:1]};
                        sr_at_hi_nx = {{8{at_bits[1]}}, sr_at_hi[8:1]};
                        v_nx        = coarse_x_inc(v);
                    end
                endcase
            end

            // Dot 255 is also fetch phase 7: chain the Y increment onto the
            // coarse-X result. The two touch disjoint bits of v.
            if (active_line && (x_idx == 10'd255)) begin
                v_nx = y_inc(v_nx);
            end

            if (active_line && (x_idx == 10'd256)) begin
                v_nx[4:0] = scroll_t[4:0];
                v_nx[10]  = scroll_t[10];
            end

            if (pre_vcopy) begin
                v_nx[9:5]   = scroll_t[9:5];
                v_nx[11]    = scroll_t[11];
                v_nx[14:12] = scroll_t[14:12];
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v         <= '0;
            nt_idx    <= '0;
            at_bits   <= '0;
            pt_lo_lat <= '0;
            pt_hi_lat <= '0;
            sr_pt_lo  <= '0;
            sr_pt_hi  <= '0;
            sr_at_lo  <= '0;
            sr_at_hi  <= '0;
            VRAM_addr <= '0;
        end else begin
            v         <= v_nx;
            nt_idx    <= nt_idx_nx;
            at_bits   <= at_bits_nx;
            pt_lo_lat <= pt_lo_lat_nx;
            pt_hi_lat <= pt_hi_lat_nx;
            sr_pt_lo  <= sr_pt_lo_nx;
            sr_pt_hi  <= sr_pt_hi_nx;
            sr_at_lo  <= sr_at_lo_nx;
            sr_at_hi  <= sr_at_hi_nx;
            VRAM_addr <= addr_nx;
        end
    end

    // ------------------------------------------------------------------
    // Pixel output
    // ------------------------------------------------------------------
`ifdef PPU_BG_CLIP_EN
    logic clip_left;
    assign clip_left = !show_left && (x_idx < 10'd8);
`else
    logic clip_left;
    logic show_left_unused;
    assign clip_left        = 1'b0;
    assign show_left_unused = show_left;
`endif

    always_comb begin
        pixel = {sr_at_hi[fine_x], sr_at_lo[fine_x], sr_pt_hi[fine_x], sr_pt_lo[fine_x]};
        if (!reset || !rendering_en || (scanline >= VIS_L) || (x_idx >= 10'd256) || clip_left) begin
            pixel = 4'd0;
        end
    end

endmodule

// File: doc/ppu_bg_scroll.md
PPU_BG_SCROLL -- requirements
Module: ppu_bg_scroll

Interface
REQ-001 SHALL have parameter NT_BASE, default 16'h2000, the nametable base address.
REQ-002 SHALL have parameter AT_OFFSET, default 16'h03C0, the attribute table offset within a nametable.
REQ-003 SHALL have parameter VISIBLE_LINES, default 240, the number of rendered scanlines (0..VISIBLE_LINES-1).
REQ-004 SHALL have parameter PRERENDER_LINE, default 261, the pre-render scanline number.
REQ-005 SHALL have the following ports (clock and reset first):
- clk  in  1  the single clock.
- reset  in  1  asynchronous, active-low reset.
- rendering_en  in  1  background rendering enable.
- VRAM_data_in  in  8  VRAM read data.
- VRAM_addr  out  16  registered VRAM read address.
- x_idx  in  10  dot index, 0..340.
- scanline  in  10  scanline index, 0..PRERENDER_LINE.
- bg_pt_addr  in  1  background pattern table select.
- scroll_t  in  15  loopy temporary address t: [4:0] coarse X, [9:5] coarse Y, [11:10] nametable, [14:12] fine Y.
- fine_x  in  3  fine X scroll.
- show_left  in  1  enables background pixels in columns 0..7.
- pixel  out  4  palette index {AT_hi, AT_lo, PT_hi, PT_lo}.

Function
REQ-006 SHALL define active_line as (scanline < VISIBLE_LINES) or (scanline == PRERENDER_LINE).
REQ-007 SHALL define the fetch window as active_line with x_idx < 256 or 320 <= x_idx < 336.
REQ-008 SHALL run, while rendering_en=1 and in the fetch window, an 8-dot fetch sequence keyed on x_idx[2:0]:
- 0: VRAM_addr <= NT_BASE | v[11:0].
- 1: latch tile index.
- 2: VRAM_addr <= NT_BASE | AT_OFFSET | v[11:10]<<10 | v[9:7]<<3 | v[4:2].
- 3: latch the 2-bit attribute selected by {v[6], v[1]}: 00 -> bits[1:0], 01 -> [3:2], 10 -> [5:4], 11 -> [7:6].
- 4: VRAM_addr <= {3'b0, bg_pt_addr, index, 1'b0, v[14:12]}.
- 5: latch low plane; VRAM_addr <= the same address with the plane bit set to 1.
- 6: latch high plane.
- 7: reload the upper 8 bits of the pattern shift registers, bit-reversed, and the upper 8 bits of both 16-bit attribute shift registers with the replicated attribute bits; increment coarse X.
REQ-009 SHALL shift all four 16-bit shift registers right by one on every fetch-window dot while rendering_en=1.
REQ-010 SHALL, on a coarse X increment, wrap v[4:0] from 31 to 0 and toggle v[10]; otherwise add 1.
REQ-011 SHALL increment Y at x_idx==255 on active_line:
- fine Y < 7: fine Y += 1.
- otherwise: fine Y = 0, then coarse Y:
  - 29 -> 0 and toggle v[11].
  - 31 -> 0 without toggle.
  - any other value: += 1.
REQ-012 SHALL copy v[4:0] and v[10] from scroll_t at x_idx==256 on active_line.
REQ-013 SHALL copy v[9:5], v[11] and v[14:12] from scroll_t on every dot with scanline==PRERENDER_LINE and 280 <= x_idx <= 304.
REQ-014 SHALL drive pixel combinationally, with zero added latency, from bit fine_x of each of the four shift registers.
REQ-015 SHALL force pixel to 0 when rendering_en=0, when scanline >= VISIBLE_LINES, or when x_idx >= 256.
REQ-016 SHALL, while rendering_en=0, freeze v, the shift registers and the latches, and hold VRAM_addr.
REQ-017 SHALL, when dot 255 is also a fetch dot 7, apply the coarse X increment and the Y increment in the same cycle, with no lost update.

Reset
REQ-018 SHALL, when reset is low, immediately clear v, all latches, all shift registers and VRAM_addr to 0, regardless of clk.
REQ-019 SHALL produce pixel = 0 during reset.
REQ-020 SHALL restart the fetch sequence from the current x_idx after reset is released mid-line, with no recovery state.

Configuration
REQ-021 SHALL, with PPU_BG_CLIP_EN defined, force pixel to 0 for x_idx < 8 when show_left=0.
REQ-022 SHALL, without PPU_BG_CLIP_EN, ignore show_left and apply no column clipping.

Verification
REQ-023 SHALL cover: scroll_t=0, fine_x=0, scanline 0 -> addresses at dots 0/2/4/5 are 16'h2002/16'h23C0/PT low/PT high per the dot-320 prefetch.
REQ-024 SHALL cover: v[4:0]=31, v[10]=0, dot 7 -> v[4:0]=0, v[10]=1.
REQ-025 SHALL cover: fine Y 7 and coarse Y 29 at dot 255 -> coarse Y 0, v[11] toggled; coarse Y 31 -> 0, v[11] unchanged.
REQ-026 SHALL cover: fine_x=3 with pattern low byte 8'h80 loaded -> pixel[0]=1 three dots earlier than with fine_x=0.
REQ-027 SHALL cover: reset asserted low at dot 100 -> VRAM_addr=0 and pixel=0 before the next clk edge.
REQ-028 SHALL cover: PPU_BG_CLIP_EN defined, show_left=0 -> pixel=0 for x_idx 0..7 and non-zero data visible from x_idx 8.
